// File: rtl/cadu_frame_sync.sv
// Bit-serial CADU frame synchroniser: ASM search, flywheel lock, MSB-first CVCDU byte packing.
// Optional macro CADU_DERAND_EN enables CCSDS PN derandomisation of payload bytes.
module cadu_frame_sync (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       bit_in,
  input  logic       bit_valid_in,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  output logic       new_cvcdu_out,
  output logic       locked_out,
  output logic [1:0] asm_miss_out
);

  localparam logic [31:0] ASM         = 32'h1ACFFC1D;
  localparam int unsigned ASM_TOL     = 3;
  localparam int unsigned CVCDU_BYTES = 1020;
  localparam int unsigned MISS_MAX    = 3;

  typedef enum logic [1:0] {SEARCH, PAYLOAD, ASM_CHECK} state_t;

  state_t      r_state;
  // The 31 most recent bits; together with bit_in they form the 32-bit window.
  logic [30:0] r_sreg;
  logic [2:0]  r_bit_cnt;
  logic [4:0]  r_chk_cnt;
  logic [9:0]  r_byte_cnt;
  logic [6:0]  r_byte_sh;
  logic [31:0] w_sreg_next;
  logic [31:0] w_diff;
  logic [5:0]  w_dist;
  logic        w_match;
  logic [7:0]  w_byte;

  assign w_sreg_next = {r_sreg, bit_in};
  assign w_diff      = w_sreg_next ^ ASM;
  assign w_match     = (w_dist <= 6'(ASM_TOL));

  // Hamming distance of the window including the current bit
  always_comb begin
    w_dist = '0;
    for (int i = 0; i < 32; i++) begin
      w_dist = w_dist + 6'(w_diff[i]);
    end
  end

`ifdef CADU_DERAND_EN
  logic [7:0] r_lfsr;

  // Window over h(x)=x^8+x^7+x^5+x^3+1: bit 7 is the oldest output bit, so the
  // register value itself is the PN byte for the current payload byte.
  function automatic logic [7:0] pn_adv8(input logic [7:0] s);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < 8; i++) begin
      v = {v[6:0], v[0] ^ v[2] ^ v[4] ^ v[7]};
    end
    return v;
  endfunction

  assign w_byte = {r_byte_sh, bit_in} ^ r_lfsr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_lfsr <= 8'hFF;
    end else if (bit_valid_in) begin
      if ((r_state == SEARCH && w_match) || (r_state == ASM_CHECK && r_chk_cnt == 5'd31)) begin
        r_lfsr <= 8'hFF;
      end else if (r_state == PAYLOAD && r_bit_cnt == 3'd7) begin
        r_lfsr <= pn_adv8(r_lfsr);
      end
    end
  end
`else
  assign w_byte = {r_byte_sh, bit_in};
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= SEARCH;
      r_sreg         <= '0;
      r_bit_cnt      <= '0;
      r_chk_cnt      <= '0;
      r_byte_cnt     <= '0;
      r_byte_sh      <= '0;
      byte_out       <= '0;
      byte_valid_out <= 1'b0;
      new_cvcdu_out  <= 1'b0;
      locked_out     <= 1'b0;
      asm_miss_out   <= '0;
    end else begin
      byte_valid_out <= 1'b0;
      new_cvcdu_out  <= 1'b0;
      if (bit_valid_in) begin
        r_sreg <= w_sreg_next[30:0];
        case (r_state)
          SEARCH: begin
            if (w_match) begin
              r_state      <= PAYLOAD;
              locked_out   <= 1'b1;
              r_bit_cnt    <= '0;
              r_chk_cnt    <= '0;
              r_byte_cnt   <= '0;
              asm_miss_out <= '0;
            end
          end
          PAYLOAD: begin
            r_byte_sh <= {r_byte_sh[5:0], bit_in};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              byte_out       <= w_byte;
              byte_valid_out <= 1'b1;
              new_cvcdu_out  <= (r_byte_cnt == 10'd0);
              if (r_byte_cnt == 10'(CVCDU_BYTES - 1)) begin
                r_byte_cnt <= '0;
                r_chk_cnt  <= '0;
                r_state    <= ASM_CHECK;
              end else begin
                r_byte_cnt <= r_byte_cnt + 10'd1;
              end
            end
          end
          ASM_CHECK: begin
            r_chk_cnt <= r_chk_cnt + 5'd1;
            if (r_chk_cnt == 5'd31) begin
              r_bit_cnt <= '0;
              if (w_match) begin
                asm_miss_out <= '0;
                r_state      <= PAYLOAD;
              end else if (asm_miss_out == 2'(MISS_MAX - 1)) begin
                asm_miss_out <= 2'(MISS_MAX);
                locked_out   <= 1'b0;
                r_state      <= SEARCH;
              end else begin
                // Flywheel: keep framing through a corrupted marker
                asm_miss_out <= asm_miss_out + 2'd1;
                r_state      <= PAYLOAD;
              end
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cadu_frame_sync.sv
// Scoreboard bench for cadu_frame_sync: expected bytes queued as stimulus is driven, popped on strobes.
module tb_cadu_frame_sync;

  localparam logic [31:0] ASM    = 32'h1ACFFC1D;
  localparam int unsigned NBYTES = 1020;
`ifdef CADU_DERAND_EN
  localparam bit DERAND = 1'b1;
`else
  localparam bit DERAND = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       bit_in;
  logic       bit_valid_in;
  logic [7:0] byte_out;
  logic       byte_valid_out;
  logic       new_cvcdu_out;
  logic       locked_out;
  logic [1:0] asm_miss_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  pn[NBYTES];
  logic        pn_bits[NBYTES*8];

  always #5 clk_in = ~clk_in;

  cadu_frame_sync dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .bit_in         (bit_in),
    .bit_valid_in   (bit_valid_in),
    .byte_out       (byte_out),
    .byte_valid_out (byte_valid_out),
    .new_cvcdu_out  (new_cvcdu_out),
    .locked_out     (locked_out),
    .asm_miss_out   (asm_miss_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard
  always @(negedge clk_in) begin
    if (byte_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(byte_valid_out), 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("byte", 32'(byte_out), 32'(e[7:0]));
        chk("new_cvcdu", 32'(new_cvcdu_out), 32'(e[8]));
      end
    end else if (new_cvcdu_out === 1'b1) begin
      chk("lone_new_cvcdu", 32'(new_cvcdu_out), 32'd0);
    end
  end

  task automatic send_bit(input logic b, input int gap);
    @(posedge clk_in); #1;
    bit_in       = b;
    bit_valid_in = 1'b1;
    repeat (gap) begin
      @(posedge clk_in); #1;
      bit_valid_in = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      bit_valid_in = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 31; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
  endtask

  // mode 0: zeros, 1: n mod 252, 2: random
  task automatic send_bytes(input int mode, input int count, input int gap);
    logic [7:0] d;
    logic [7:0] e;
    for (int n = 0; n < count; n++) begin
      case (mode)
        0:       d = 8'h00;
        1:       d = 8'(n % 252);
        default: d = 8'($urandom);
      endcase
      e = DERAND ? (d ^ pn[n]) : d;
      exp_q.push_back({(n == 0), e});
      send_byte(d, gap);
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk_in); #1;
    rst_in       = 1'b1;
    bit_valid_in = 1'b1;
    bit_in       = 1'($urandom);
    repeat (ncyc) begin
      @(posedge clk_in); #1;
      bit_in = 1'($urandom);
    end
    rst_in       = 1'b0;
    bit_valid_in = 1'b0;
  endtask

  initial begin
    rst_in       = 1'b1;
    bit_in       = 1'b0;
    bit_valid_in = 1'b0;

    // PN reference from the recurrence a[n+8] = a[n+7]^a[n+5]^a[n+3]^a[n], seed all ones
    for (int i = 0; i < NBYTES*8; i++) begin
      pn_bits[i] = (i < 8) ? 1'b1 : (pn_bits[i-1] ^ pn_bits[i-3] ^ pn_bits[i-5] ^ pn_bits[i-8]);
    end
    for (int k = 0; k < NBYTES; k++) begin
      for (int b = 0; b < 8; b++) pn[k][7-b] = pn_bits[8*k+b];
    end

    do_reset(3);
    chk("rst_byte", 32'(byte_out), 32'd0);
    chk("rst_valid", 32'(byte_valid_out), 32'd0);
    chk("rst_new", 32'(new_cvcdu_out), 32'd0);
    chk("rst_locked", 32'(locked_out), 32'd0);
    chk("rst_miss", 32'(asm_miss_out), 32'd0);

    // Clean frame, bits spaced 3 cycles
    for (int i = 0; i < 8; i++) send_bit(1'($urandom), 2);
    for (int i = 31; i >= 1; i--) send_bit(ASM[i], 2);
    chk("no_early_lock", 32'(locked_out), 32'd0);
    send_bit(ASM[0], 2);
    chk("lock_clean", 32'(locked_out), 32'd1);
    send_bytes(1, NBYTES, 2);
    idle(2);
    chk("frame1_all_out", 32'(exp_q.size()), 32'd0);
    chk("frame1_locked", 32'(locked_out), 32'd1);

    // Flywheel through two bad markers, then a clean one
    send_word(~ASM, 0); idle(1);
    chk("fly_miss1", 32'(asm_miss_out), 32'd1);
    chk("fly_locked1", 32'(locked_out), 32'd1);
    send_bytes(0, NBYTES, 0);
    send_word(~ASM, 0); idle(1);
    chk("fly_miss2", 32'(asm_miss_out), 32'd2);
    chk("fly_locked2", 32'(locked_out), 32'd1);
    send_bytes(2, NBYTES, 0);
    send_word(ASM, 0); idle(1);
    chk("fly_miss0", 32'(asm_miss_out), 32'd0);
    chk("fly_locked3", 32'(locked_out), 32'd1);
    send_bytes(1, NBYTES, 0);
    idle(2);
    chk("fly_frames_out", 32'(exp_q.size()), 32'd0);

    // Three consecutive bad markers drop lock
    send_word(~ASM, 0); idle(1);
    chk("loss_miss1", 32'(asm_miss_out), 32'd1);
    send_bytes(0, NBYTES, 0);
    send_word(~ASM, 0); idle(1);
    chk("loss_miss2", 32'(asm_miss_out), 32'd2);
    send_bytes(1, NBYTES, 0);
    send_word(~ASM, 0); idle(1);
    chk("loss_unlocked", 32'(locked_out), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'h00, 0);
    idle(3);
    chk("loss_no_frame", 32'(exp_q.size()), 32'd0);
    chk("loss_still_unlocked", 32'(locked_out), 32'd0);

    // Tolerance: 3 bit errors lock, 4 do not
    do_reset(3);
    send_byte(8'h00, 0);
    send_word(ASM ^ 32'h8001_0001, 0); idle(1);
    chk("tol3_locked", 32'(locked_out), 32'd1);
    send_bytes(2, 3, 0);
    idle(2);
    chk("tol3_bytes", 32'(exp_q.size()), 32'd0);
    do_reset(3);
    send_byte(8'h00, 0);
    send_word(ASM ^ 32'h8001_0101, 0); idle(1);
    chk("tol4_unlocked", 32'(locked_out), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    idle(2);
    chk("tol4_unlocked_after", 32'(locked_out), 32'd0);

    // Mid-frame reset at byte 500, then relock with a fresh frame
    do_reset(3);
    send_word(ASM, 0);
    send_bytes(1, 500, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    do_reset(2);
    chk("mid_rst_locked", 32'(locked_out), 32'd0);
    chk("mid_rst_valid", 32'(byte_valid_out), 32'd0);
    chk("mid_rst_miss", 32'(asm_miss_out), 32'd0);
    idle(4);
    chk("mid_rst_drained", 32'(exp_q.size()), 32'd0);
    send_word(ASM, 0);
    send_bytes(1, 4, 0);
    idle(3);
    chk("relock_bytes", 32'(exp_q.size()), 32'd0);
    chk("relock_locked", 32'(locked_out), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
